sram_ctrl_2048_8: RTL and testbench

Synchronous host-side controller that drives the 2048x8 asynchronous SRAM (active-low CS_b/OE_b/WE_b, bidirectional data bus). It accepts single-word read/write requests over a req/ready handshake and sequences the SRAM strobes, address and three-state data bus in whole clock cycles. Cycle counts are parameterised so the SRAM access, write-pulse and bus-release times are met at the system clock period (default 10 ns).

---
 rtl/sram_ctrl_2048_8.sv | 175 +++++++++++++++++
 tb/tb_sram_ctrl_2048_8.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_2048_8.sv
// Host-side sequencer for a 2048x8 asynchronous SRAM: one word per req/ready
// handshake, with all strobes, address and bus drive enable taken from flops.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready = 1, waiting for req; strobes high, bus released
// WR_SETUP  | CS_b low, address and write data driven, WE_b still high
// WR_PULSE  | WE_b low for WP_CYCLES cycles
// WR_HOLD   | WE_b high again, address/data held, CS_b still low
// RD_ACCESS | CS_b/OE_b low for RD_CYCLES cycles, capture on the final edge
// RD_TURN   | strobes high, bus released for TURN_CYCLES before reuse
`timescale 1ns/1ps

module sram_ctrl_2048_8 #(
    parameter int word_size   = 8,
    parameter int addr_size   = 11,
    parameter int WP_CYCLES   = 1,
    parameter int RD_CYCLES   = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset_b,
    input  logic                 req,
    input  logic                 rw,
    input  logic [addr_size-1:0] addr_in,
    input  logic [word_size-1:0] wdata,
    output logic                 ready,
    output logic [word_size-1:0] rdata,
    output logic                 rvalid,
    output logic                 done,
    output logic [addr_size-1:0] sram_addr,
    inout  wire  [word_size-1:0] sram_data,
    output logic                 CS_b,
    output logic                 OE_b,
    output logic                 WE_b
);

    localparam int WR_MAX  = (WP_CYCLES > RD_CYCLES) ? WP_CYCLES : RD_CYCLES;
    localparam int CNT_MAX = (WR_MAX > TURN_CYCLES) ? WR_MAX : TURN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // The counter holds "cycles remaining minus one", so terminal count is zero.
    localparam logic [CNT_W-1:0] WP_LOAD   = CNT_W'(WP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ACCESS,
        RD_TURN
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   cnt_tc;
    logic                   ready_q;
    logic                   cs_b_q;
    logic                   oe_b_q;
    logic                   we_b_q;
    logic                   drive_q;
    logic                   done_q;
    logic                   rvalid_q;
    logic [addr_size-1:0]   addr_q;
    logic [word_size-1:0]   wdata_q;
    logic [word_size-1:0]   rdata_q;

    assign cnt_tc = (cnt_q == '0);

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            cs_b_q   <= 1'b1;
            oe_b_q   <= 1'b1;
            we_b_q   <= 1'b1;
            drive_q  <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req && ready_q) begin
                        addr_q  <= addr_in;
                        cs_b_q  <= 1'b0;
                        ready_q <= 1'b0;
                        if (rw) begin
                            state_q <= RD_ACCESS;
                            oe_b_q  <= 1'b0;
                            cnt_q   <= RD_LOAD;
                        end else begin
                            state_q <= WR_SETUP;
                            wdata_q <= wdata;
                            drive_q <= 1'b1;
                        end
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    we_b_q  <= 1'b0;
                    cnt_q   <= WP_LOAD;
                end
                WR_PULSE: begin
                    if (cnt_tc) begin
                        state_q <= WR_HOLD;
                        we_b_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    state_q <= IDLE;
                    cs_b_q  <= 1'b1;
                    drive_q <= 1'b0;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                end
                RD_ACCESS: begin
                    if (cnt_tc) begin
                        rdata_q  <= sram_data;
                        rvalid_q <= 1'b1;
                        cs_b_q   <= 1'b1;
                        oe_b_q   <= 1'b1;
                        if (TURN_CYCLES == 0) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= RD_TURN;
                            cnt_q   <= TURN_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RD_TURN: begin
                    if (cnt_tc) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    cs_b_q  <= 1'b1;
                    oe_b_q  <= 1'b1;
                    we_b_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus is only ever driven from the write states; OE_b is high throughout them.
    assign sram_data = drive_q ? wdata_q : {word_size{1'bz}};

    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign done      = done_q;
    assign sram_addr = addr_q;
    assign CS_b      = cs_b_q;
    assign OE_b      = oe_b_q;
    assign WE_b      = we_b_q;

endmodule

// File: tb/tb_sram_ctrl_2048_8.sv
// Bench for sram_ctrl_2048_8: behavioural async SRAM on the bus, reference
// memory image and cycle expectations derived from the controller's timing rules.
`timescale 1ns/1ps

module tb_sram_ctrl_2048_8;

    logic        clock = 1'b0;
    logic        reset_b = 1'b1;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [10:0] addr_in = '0;
    logic [7:0]  wdata = '0;
    logic        ready;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        done;
    logic [10:0] sram_addr;
    wire  [7:0]  sram_data;
    logic        CS_b;
    logic        OE_b;
    logic        WE_b;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem     [2048];
    logic [7:0] ref_mem [2048];
    logic       probe_en  = 1'b0;
    logic [7:0] probe_val = '0;

    sram_ctrl_2048_8 dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .req       (req),
        .rw        (rw),
        .addr_in   (addr_in),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .done      (done),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .CS_b      (CS_b),
        .OE_b      (OE_b),
        .WE_b      (WE_b)
    );

    always #5 clock = ~clock;

    // Asynchronous SRAM: drives when selected and output-enabled, writes on WE_b rising.
    assign sram_data = (!CS_b && !OE_b && WE_b) ? mem[sram_addr] : 8'bz;
    assign sram_data = probe_en ? probe_val : 8'bz;

    always @(posedge WE_b) begin
        if (!CS_b && reset_b) mem[sram_addr] <= sram_data;
    end

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clock);
        while (!ready && n < 30) begin
            @(negedge clock);
            n++;
        end
        n_assert++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_timeout: ready=%b required 1", tag, ready);
        end
    endtask

    // One complete access, observed over the six cycles after the accept edge.
    task automatic access(input logic rd, input logic [10:0] a, input logic [7:0] d, input string tag);
        int cs_low, oe_low, we_low, done_cyc, done_cnt, rv_cyc, rv_cnt, rdy_cyc, bus_bad, addr_bad;
        logic [7:0] rv_val;
        logic [7:0] exp;
        cs_low = 0; oe_low = 0; we_low = 0; done_cyc = 0; done_cnt = 0;
        rv_cyc = 0; rv_cnt = 0; rdy_cyc = 0; bus_bad = 0; addr_bad = 0; rv_val = '0;
        exp = rd ? ref_mem[a] : d;
        wait_ready(tag);
        req = 1'b1; rw = rd; addr_in = a; wdata = d;
        @(posedge clock);
        #1;
        req = 1'b0; addr_in = 11'($urandom); wdata = 8'($urandom);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            if (!CS_b) cs_low++;
            if (!OE_b) oe_low++;
            if (!WE_b) we_low++;
            if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
            if (rvalid) begin rv_cnt++; if (rv_cyc == 0) begin rv_cyc = c; rv_val = rdata; end end
            if (ready && rdy_cyc == 0) rdy_cyc = c;
            if (!rd && !CS_b && sram_data !== d) bus_bad++;
            if (!CS_b && sram_addr !== a) addr_bad++;
        end
        n_assert++;
        if (rdy_cyc !== 4) begin n_fail++; $display("FAIL %s ready_cycle: got %0d required 4", tag, rdy_cyc); end
        n_assert++;
        if (addr_bad !== 0) begin n_fail++; $display("FAIL %s addr_stable: %0d bad cycles required 0", tag, addr_bad); end
        n_assert++;
        if (sram_addr !== a) begin n_fail++; $display("FAIL %s addr_hold: got %h required %h", tag, sram_addr, a); end
        if (!rd) begin
            n_assert++;
            if (done_cyc !== 4 || done_cnt !== 1) begin n_fail++; $display("FAIL %s done: cycle %0d count %0d required cycle 4 count 1", tag, done_cyc, done_cnt); end
            n_assert++;
            if (cs_low !== 3) begin n_fail++; $display("FAIL %s cs_low: got %0d required 3", tag, cs_low); end
            n_assert++;
            if (we_low !== 1) begin n_fail++; $display("FAIL %s we_low: got %0d required 1", tag, we_low); end
            n_assert++;
            if (oe_low !== 0 || rv_cnt !== 0) begin n_fail++; $display("FAIL %s wr_no_read: oe_low %0d rvalid %0d required 0 0", tag, oe_low, rv_cnt); end
            n_assert++;
            if (bus_bad !== 0) begin n_fail++; $display("FAIL %s wr_bus: %0d bad cycles required 0", tag, bus_bad); end
            ref_mem[a] = d;
        end else begin
            n_assert++;
            if (rv_cyc !== 3 || rv_cnt !== 1) begin n_fail++; $display("FAIL %s rvalid: cycle %0d count %0d required cycle 3 count 1", tag, rv_cyc, rv_cnt); end
            n_assert++;
            if (rv_val !== exp) begin n_fail++; $display("FAIL %s rdata: got %h required %h addr %h", tag, rv_val, exp, a); end
            n_assert++;
            if (rdata !== exp) begin n_fail++; $display("FAIL %s rdata_hold: got %h required %h", tag, rdata, exp); end
            n_assert++;
            if (cs_low !== 2 || oe_low !== 2) begin n_fail++; $display("FAIL %s rd_strobes: cs_low %0d oe_low %0d required 2 2", tag, cs_low, oe_low); end
            n_assert++;
            if (we_low !== 0 || done_cnt !== 0) begin n_fail++; $display("FAIL %s rd_no_write: we_low %0d done %0d required 0 0", tag, we_low, done_cnt); end
        end
    endtask

    task automatic test_reset();
        #2 reset_b = 1'b0;
        #1;
        n_assert++;
        if ({CS_b, OE_b, WE_b} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes: got %b required 111", {CS_b, OE_b, WE_b}); end
        n_assert++;
        if (rvalid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: rvalid %b done %b required 0 0", rvalid, done); end
        n_assert++;
        if (sram_addr !== 11'h000 || rdata !== 8'h00) begin n_fail++; $display("FAIL reset_regs: addr %h rdata %h required 000 00", sram_addr, rdata); end
        probe_en = 1'b1; probe_val = 8'h5A;
        #1;
        n_assert++;
        if (sram_data !== 8'h5A) begin n_fail++; $display("FAIL reset_bus_released: got %h required 5a", sram_data); end
        probe_en = 1'b0;
        repeat (3) @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);
        n_assert++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ready); end
    endtask

    task automatic test_single();
        access(1'b0, 11'h005, 8'hA5, "single_wr");
        access(1'b1, 11'h005, 8'h00, "single_rd");
    endtask

    task automatic test_back_to_back();
        int done_cyc, rd_start, oe_last, rv_cyc, wr2_start, gap_cs, bus_bad;
        logic [7:0] rv_val;
        done_cyc = 0; rd_start = 0; oe_last = 0; rv_cyc = 0; wr2_start = 0; gap_cs = 0; bus_bad = 0; rv_val = '0;
        wait_ready("b2b");
        req = 1'b1; rw = 1'b0; addr_in = 11'h7FF; wdata = 8'h3C;
        @(posedge clock);
        #1 rw = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            if (done && done_cyc == 0) done_cyc = c;
            if (!OE_b) begin if (rd_start == 0) rd_start = c; oe_last = c; end
            if (rvalid && rv_cyc == 0) begin rv_cyc = c; rv_val = rdata; end
            if (c > 5 && !CS_b && OE_b && wr2_start == 0) wr2_start = c;
            if ((c == 7 || c == 8) && !CS_b) gap_cs++;
            if (c >= 9 && c <= 11 && sram_data !== 8'hC3) bus_bad++;
            if (c == 5) begin rw = 1'b0; addr_in = 11'h7FE; wdata = 8'hC3; end
            if (c == 9) req = 1'b0;
        end
        n_assert++;
        if (done_cyc !== 4 || rd_start !== 5) begin n_fail++; $display("FAIL b2b_accept: done cycle %0d read start %0d required 4 5", done_cyc, rd_start); end
        n_assert++;
        if (rv_cyc !== 7 || rv_val !== 8'h3C) begin n_fail++; $display("FAIL b2b_read: rvalid cycle %0d data %h required 7 3c", rv_cyc, rv_val); end
        n_assert++;
        if (oe_last !== 6 || wr2_start !== 9 || gap_cs !== 0) begin n_fail++; $display("FAIL b2b_turn: oe_last %0d wr2_start %0d gap_cs %0d required 6 9 0", oe_last, wr2_start, gap_cs); end
        n_assert++;
        if (bus_bad !== 0) begin n_fail++; $display("FAIL b2b_wr2_bus: %0d bad cycles required 0", bus_bad); end
        ref_mem[11'h7FF] = 8'h3C;
        ref_mem[11'h7FE] = 8'hC3;
        access(1'b1, 11'h7FE, 8'h00, "b2b_rd2");
    endtask

    task automatic test_busy();
        int cs_low, oe_low, rv_cnt, done_cyc;
        cs_low = 0; oe_low = 0; rv_cnt = 0; done_cyc = 0;
        wait_ready("busy");
        req = 1'b1; rw = 1'b0; addr_in = 11'h123; wdata = 8'h5A;
        @(posedge clock);
        #1 req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (!CS_b) cs_low++;
            if (!OE_b) oe_low++;
            if (rvalid) rv_cnt++;
            if (done && done_cyc == 0) done_cyc = c;
            if (c == 2) begin req = 1'b1; rw = 1'b1; addr_in = 11'h456; end
            if (c == 3) req = 1'b0;
        end
        n_assert++;
        if (cs_low !== 3 || oe_low !== 0 || rv_cnt !== 0) begin n_fail++; $display("FAIL busy_ignored: cs_low %0d oe_low %0d rvalid %0d required 3 0 0", cs_low, oe_low, rv_cnt); end
        n_assert++;
        if (done_cyc !== 4) begin n_fail++; $display("FAIL busy_done: cycle %0d required 4", done_cyc); end
        ref_mem[11'h123] = 8'h5A;
        access(1'b1, 11'h123, 8'h00, "busy_rd");
    endtask

    task automatic test_walking();
        logic [7:0] d;
        for (int i = 0; i < 2048; i++) begin
            d = 8'(1 << (i % 8));
            access(1'b0, 11'(i), d, "walk_wr");
        end
        for (int i = 0; i < 2048; i++) access(1'b1, 11'(i), 8'h00, "walk_rd");
    endtask

    task automatic test_random();
        logic [10:0] a;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
            access(1'($urandom_range(0, 1)), a, 8'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_write();
        access(1'b0, 11'h001, 8'hE7, "pre_reset_wr");
        access(1'b1, 11'h001, 8'h00, "pre_reset_rd");
        wait_ready("mid_reset");
        req = 1'b1; rw = 1'b0; addr_in = 11'h0AA; wdata = 8'h99;
        @(posedge clock);
        #1 req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_assert++;
        if (WE_b !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pulse: WE_b %b required 0", WE_b); end
        #2 reset_b = 1'b0;
        #1;
        n_assert++;
        if ({CS_b, OE_b, WE_b} !== 3'b111) begin n_fail++; $display("FAIL mid_reset_strobes: got %b required 111", {CS_b, OE_b, WE_b}); end
        probe_en = 1'b1; probe_val = 8'h00;
        #1;
        n_assert++;
        if (sram_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_bus_released: got %h required 00", sram_data); end
        probe_en = 1'b0;
        @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);
        n_assert++;
        if (ready !== 1'b1 || rdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_after: ready %b rdata %h required 1 00", ready, rdata); end
        n_assert++;
        if (done !== 1'b0 || rvalid !== 1'b0 || sram_addr !== 11'h000) begin n_fail++; $display("FAIL mid_reset_regs: done %b rvalid %b addr %h required 0 0 000", done, rvalid, sram_addr); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_walking();
        test_random();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
